// File: rtl/fp32_arb_pkg.sv
// Shared types and constants for the round-robin FP32 adder arbiter.
package fp32_arb_pkg;
  localparam int FP32_W      = 32;
  localparam int DEF_NUM_REQ = 4;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} arb_state_e;

  // Leading-zero count of the 27-bit adder working mantissa; 27 for zero.
  function automatic logic [4:0] clz27(input logic [26:0] v);
    clz27 = 5'd27;
    for (int i = 0; i < 27; i++)
      if (v[i]) clz27 = 5'(26 - i);
  endfunction
endpackage

// File: rtl/adderfp32.sv
// Combinational IEEE-754 single adder, round-to-nearest-even, with
// denormal, infinity and NaN handling.
module adderfp32
  import fp32_arb_pkg::*;
(
  input  logic              rst,
  input  logic [FP32_W-1:0] a,
  input  logic [FP32_W-1:0] b,
  output logic [FP32_W-1:0] y
);
  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  logic        a_nan, b_nan, a_inf, b_inf, eff_sub, up, hid;
  logic [31:0] xw, yw;
  logic [7:0]  ex, ey, d;
  logic [26:0] mx, my, my_sh, diff, m;
  logic [27:0] sum;
  logic [4:0]  lz;
  logic [9:0]  e, sh, er;
  logic [24:0] mr;
  logic [22:0] frac;

  always_comb begin
    a_nan = (&a[30:23]) && (a[22:0] != '0);
    b_nan = (&b[30:23]) && (b[22:0] != '0);
    a_inf = (&a[30:23]) && (a[22:0] == '0);
    b_inf = (&b[30:23]) && (b[22:0] == '0);
    // x always carries the larger magnitude, so the subtract never goes negative
    xw = (b[30:0] > a[30:0]) ? b : a;
    yw = (b[30:0] > a[30:0]) ? a : b;
    ex = (xw[30:23] == '0) ? 8'd1 : xw[30:23];
    ey = (yw[30:23] == '0) ? 8'd1 : yw[30:23];
    mx = {|xw[30:23], xw[22:0], 3'b000};
    my = {|yw[30:23], yw[22:0], 3'b000};
    d  = ex - ey;
    my_sh   = (my >> d) | {26'b0, |(my & ~({27{1'b1}} << d))};
    eff_sub = xw[31] ^ yw[31];
    sum     = {1'b0, mx} + {1'b0, my_sh};
    diff    = mx - my_sh;
    lz      = clz27(diff);
    sh      = '0;
    m       = '0;
    e       = '0;
    if (!eff_sub) begin
      if (sum[27]) begin
        m = {sum[27:2], sum[1] | sum[0]};
        e = {2'b0, ex} + 10'd1;
      end else begin
        m = sum[26:0];
        e = {2'b0, ex};
      end
    end else begin
      // normalise left, but never below the denormal exponent
      sh = ({5'b0, lz} > ({2'b0, ex} - 10'd1)) ? ({2'b0, ex} - 10'd1) : {5'b0, lz};
      m  = diff << sh;
      e  = {2'b0, ex} - sh;
    end
    up   = m[2] & (m[1] | m[0] | m[3]);
    mr   = {1'b0, m[26:3]} + {24'b0, up};
    er   = mr[24] ? e + 10'd1 : e;
    hid  = mr[24] | mr[23];
    frac = mr[24] ? 23'd0 : mr[22:0];

    if (rst)                                        y = '0;
    else if (a_nan || b_nan || (a_inf && b_inf && (a[31] ^ b[31]))) y = QNAN;
    else if (a_inf)                                 y = a;
    else if (b_inf)                                 y = b;
    else if (eff_sub && diff == '0)                 y = '0;
    else if (er >= 10'd255)                         y = {xw[31], 8'hFF, 23'b0};
    else                                            y = {xw[31], hid ? er[7:0] : 8'd0, frac};
  end
endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first valid index at or after rr_ptr.
module rr_arbiter
  import fp32_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    rr_ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    gnt_idx,
  output logic               gnt_any
);
  always_comb begin
    int idx;
    logic [ID_W-1:0] ix;
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    idx     = 0;
    ix      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = int'(rr_ptr) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      ix = ID_W'(idx);
      if (!gnt_any && req[ix]) begin
        gnt_any = 1'b1;
        gnt_idx = ix;
        gnt[ix] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/fp32_add_arbiter.sv
// Shares one FP32 adder among NUM_REQ requesters: round-robin accept,
// one cycle of add, then a held response until the owner takes it.
module fp32_add_arbiter
  import fp32_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ-1:0][FP32_W-1:0] req_a,
  input  logic [NUM_REQ-1:0][FP32_W-1:0] req_b,
  output logic [NUM_REQ-1:0]             rsp_valid,
  input  logic [NUM_REQ-1:0]             rsp_ready,
  output logic [FP32_W-1:0]              rsp_sum,
  output logic [ID_W-1:0]                rsp_id,
  output logic                           busy
);
  arb_state_e         state_q, state_d;
  logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d, owner_q, owner_d;
  logic [FP32_W-1:0]  op_a_q, op_a_d, op_b_q, op_b_d, sum_q, sum_d, add_y;
  logic [NUM_REQ-1:0] gnt;
  logic [ID_W-1:0]    gnt_idx;
  logic               gnt_any;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
    .req     (req_valid),
    .rr_ptr  (rr_ptr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

  adderfp32 u_add (
    .rst (1'b0),
    .a   (op_a_q),
    .b   (op_b_q),
    .y   (add_y)
  );

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    owner_d   = owner_q;
    op_a_d    = op_a_q;
    op_b_d    = op_b_q;
    sum_d     = sum_q;
    req_ready = '0;
    rsp_valid = '0;
    unique case (state_q)
      IDLE: begin
        req_ready = gnt;
        if (gnt_any) begin
          op_a_d  = req_a[gnt_idx];
          op_b_d  = req_b[gnt_idx];
          owner_d = gnt_idx;
          state_d = EXEC;
        end
      end
      EXEC: begin
        sum_d   = add_y;
        state_d = RESP;
      end
      RESP: begin
        rsp_valid[owner_q] = 1'b1;
        // only the owner's ready matters; the pointer moves past the owner
        if (rsp_ready[owner_q]) begin
          rr_ptr_d = (owner_q == ID_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      owner_q  <= '0;
      op_a_q   <= '0;
      op_b_q   <= '0;
      sum_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      sum_q    <= sum_d;
    end
  end

  assign rsp_sum = sum_q;
  assign rsp_id  = owner_q;
  assign busy    = (state_q != IDLE);
endmodule

// File: tb/tb_fp32_add_arbiter.sv
// Self-checking bench: vector table plus hand sequences, scoreboard on responses.
module tb_fp32_add_arbiter;
  localparam int N = 4;

  typedef struct { int id; logic [31:0] a; logic [31:0] b; logic [31:0] sum; } vec_t;
  typedef struct { int id; logic [31:0] sum; } exp_t;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [N-1:0]       req_valid, req_ready, rsp_valid, rsp_ready;
  logic [N-1:0][31:0] req_a, req_b;
  logic [31:0]        rsp_sum;
  logic [1:0]         rsp_id;
  logic               busy;

  int   checks = 0, failures = 0, cyc = 0;
  exp_t sbq[$];
  exp_t mon_e;
  vec_t vecs[$];

  logic        hold_q = 1'b0;
  logic [31:0] hold_sum;
  logic [1:0]  hold_id;
  logic [N-1:0] hold_v;

  fp32_add_arbiter #(.NUM_REQ(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_sum   (rsp_sum),
    .rsp_id    (rsp_id),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // scoreboard: pop and compare on every response handshake
  always @(negedge clk) begin
    if (rst_n && (rsp_valid & rsp_ready) != '0) begin
      if (sbq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_rsp: rsp_valid=%b sum=%h id=%0d", rsp_valid, rsp_sum, rsp_id);
      end else begin
        mon_e = sbq.pop_front();
        chk("rsp_valid_owner", 32'(rsp_valid), 32'(1 << mon_e.id));
        chk("rsp_sum", rsp_sum, mon_e.sum);
        chk("rsp_id", 32'(rsp_id), 32'(mon_e.id));
      end
    end
  end

  // protocol checks: onehot0, no response outside busy, stable under backpressure
  always @(negedge clk) begin
    if (rst_n) begin
      chk("req_ready_onehot0", 32'($onehot0(req_ready)), 32'd1);
      chk("rsp_valid_onehot0", 32'($onehot0(rsp_valid)), 32'd1);
      if (rsp_valid != '0) chk("rsp_valid_busy", 32'(busy), 32'd1);
      if (hold_q) begin
        chk("hold_sum", rsp_sum, hold_sum);
        chk("hold_id", 32'(rsp_id), 32'(hold_id));
        chk("hold_valid", 32'(rsp_valid), 32'(hold_v));
      end
      hold_q   <= (rsp_valid != '0) && !rsp_ready[rsp_id];
      hold_sum <= rsp_sum;
      hold_id  <= rsp_id;
      hold_v   <= rsp_valid;
    end else begin
      hold_q <= 1'b0;
    end
  end

  task automatic add_vec(input int id, input logic [31:0] a, b, s);
    vec_t v;
    v.id = id; v.a = a; v.b = b; v.sum = s;
    vecs.push_back(v);
  endtask

  task automatic wait_grant(output int idx);
    int n = 0;
    idx = -1;
    #1;
    while (req_ready == '0 && n < 50) begin @(negedge clk); n++; end
    for (int i = 0; i < N; i++) if (req_ready[i]) idx = i;
    if (idx < 0) begin
      checks++;
      failures++;
      $display("FAIL grant_timeout: req_valid=%b req_ready=%b", req_valid, req_ready);
    end
  endtask

  // present one request, push its expectation at grant, drop valid after accept
  task automatic issue(input int id, input logic [31:0] a, b, s, input bit push, output int acc);
    int n = 0;
    acc = -1;
    req_a[id] = a;
    req_b[id] = b;
    req_valid[id] = 1'b1;
    #1;
    while (!req_ready[id] && n < 50) begin @(negedge clk); n++; end
    chk("issue_grant", 32'(req_ready[id]), 32'd1);
    if (!req_ready[id]) begin
      req_valid[id] = 1'b0;
      return;
    end
    if (push) sbq.push_back('{id, s});
    @(posedge clk);
    #1;
    acc = cyc;
    req_valid[id] = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((sbq.size() != 0 || busy) && n < 50) begin @(negedge clk); n++; end
    chk("drain", 32'(sbq.size()), 32'd0);
    sbq.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_valid = '0;
    @(negedge clk);
    @(negedge clk);
    chk("reset_req_ready", 32'(req_ready), 32'd0);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_rsp_sum", rsp_sum, 32'd0);
    chk("reset_rsp_id", 32'(rsp_id), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
  endtask

  initial begin
    int acc, lat, g, prev;
    rst_n = 1'b0; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = '1;

    add_vec(0, 32'h3F800000, 32'h40000000, 32'h40400000); // 1 + 2
    add_vec(1, 32'h40400000, 32'hBF800000, 32'h40000000); // 3 - 1
    add_vec(2, 32'h40A00000, 32'h00000000, 32'h40A00000); // 5 + 0
    add_vec(3, 32'h7F800000, 32'h3F800000, 32'h7F800000); // inf + 1
    add_vec(0, 32'h3F800000, 32'hBF800000, 32'h00000000); // 1 - 1 = +0
    add_vec(1, 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000); // overflow
    add_vec(2, 32'hC0000000, 32'hC0000000, 32'hC0800000); // -2 + -2
    add_vec(3, 32'h3F800000, 32'h33800000, 32'h3F800000); // tie to even
    add_vec(0, 32'h3F800000, 32'h33C00000, 32'h3F800001); // round up
    add_vec(1, 32'h00000001, 32'h00000001, 32'h00000002); // denormals
    add_vec(2, 32'h7FC00000, 32'h3F800000, 32'h7FC00000); // NaN

    do_reset();
    foreach (vecs[i]) begin
      issue(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].sum, 1'b1, acc);
      lat = 0;
      while (rsp_valid == '0 && lat < 10) begin @(negedge clk); lat++; end
      chk("latency", 32'(lat), 32'd2);
      drain();
    end

    // all four at once after reset: grants 0,1,2,3 spaced 3 cycles
    do_reset();
    for (int k = 0; k < N; k++) begin req_a[k] = 32'h3FC00000; req_b[k] = 32'h3FC00000; end
    req_valid = '1;
    prev = 0;
    for (int k = 0; k < N; k++) begin
      wait_grant(g);
      chk("rr_order", 32'(g), 32'(k));
      if (g < 0) break;
      sbq.push_back('{g, 32'h40400000});
      @(posedge clk);
      #1;
      if (k > 0) chk("issue_interval", 32'(cyc - prev), 32'd3);
      prev = cyc;
      req_valid[g] = 1'b0;
    end
    req_valid = '0;
    drain();

    // pointer wrapped to 0: requester 0 wins over 3
    req_valid = 4'b1001;
    wait_grant(g);
    chk("wrap_grant", 32'(g), 32'd0);
    if (g >= 0) begin sbq.push_back('{g, 32'h40400000}); @(posedge clk); #1; req_valid[g] = 1'b0; end
    wait_grant(g);
    chk("wrap_second", 32'(g), 32'd3);
    if (g >= 0) begin sbq.push_back('{g, 32'h40400000}); @(posedge clk); #1; req_valid[g] = 1'b0; end
    req_valid = '0;
    drain();

    // backpressure on requester 2; other rsp_ready bits high and ignored
    rsp_ready = 4'b1011;
    issue(2, 32'h40A00000, 32'h00000000, 32'h40A00000, 1'b1, acc);
    req_a[0] = 32'h3F800000; req_b[0] = 32'h40000000; req_valid[0] = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_rsp_valid", 32'(rsp_valid), 32'h4);
      chk("bp_rsp_sum", rsp_sum, 32'h40A00000);
      chk("bp_busy", 32'(busy), 32'd1);
      chk("bp_req_ready", 32'(req_ready), 32'd0);
    end
    @(posedge clk);
    #1;
    rsp_ready = '1;
    wait_grant(g);
    chk("bp_next_grant", 32'(g), 32'd0);
    if (g >= 0) begin sbq.push_back('{g, 32'h40400000}); @(posedge clk); #1; req_valid[g] = 1'b0; end
    req_valid = '0;
    drain();

    // reset during EXEC discards the op and clears the pointer
    issue(1, 32'h3F800000, 32'h40000000, 32'h0, 1'b0, acc);
    #3;
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midrst_req_ready", 32'(req_ready), 32'd0);
    chk("midrst_rsp_sum", rsp_sum, 32'd0);
    chk("midrst_rsp_id", 32'(rsp_id), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    req_a[0] = 32'h3FC00000; req_b[0] = 32'h3FC00000;
    req_a[3] = 32'h3FC00000; req_b[3] = 32'h3FC00000;
    req_valid = 4'b1001;
    wait_grant(g);
    chk("post_reset_grant", 32'(g), 32'd0);
    if (g >= 0) begin sbq.push_back('{g, 32'h40400000}); @(posedge clk); #1; req_valid[g] = 1'b0; end
    wait_grant(g);
    chk("post_reset_second", 32'(g), 32'd3);
    if (g >= 0) begin sbq.push_back('{g, 32'h40400000}); @(posedge clk); #1; req_valid[g] = 1'b0; end
    req_valid = '0;
    drain();
    repeat (4) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete (checks=%0d failures=%0d)", checks, failures);
    $fatal(1);
  end
endmodule
